// File: rtl/trail_arbiter.sv
// Single owner of the trail push/backtrack/clear ports: round-robin propagation grants,
// lowest-priority decisions, and sequencing of backtrack and clear with the decision level.
module trail_arbiter #(
    parameter int NUM_PROP = 4,
    parameter int VAR_W    = 32,
    parameter int LVL_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PROP-1:0]       prop_valid,
    input  logic [NUM_PROP*VAR_W-1:0] prop_var,
    input  logic [NUM_PROP-1:0]       prop_value,
    output logic [NUM_PROP-1:0]       prop_ready,
    input  logic                      dec_valid,
    input  logic [VAR_W-1:0]          dec_var,
    input  logic                      dec_value,
    output logic                      dec_ready,
    input  logic                      bt_req,
    input  logic [LVL_W-1:0]          bt_level,
    output logic                      bt_done,
    input  logic                      clear_req,
    output logic [LVL_W-1:0]          cur_level,
    output logic                      level_overflow,
    output logic                      push,
    output logic [VAR_W-1:0]          push_var,
    output logic                      push_value,
    output logic [LVL_W-1:0]          push_level,
    output logic                      push_is_decision,
    output logic                      backtrack_en,
    output logic [LVL_W-1:0]          backtrack_to_level,
    input  logic                      backtrack_done,
    output logic                      clear_all
);
    localparam int PTR_W = (NUM_PROP > 1) ? $clog2(NUM_PROP) : 1;
    localparam int CW    = PTR_W + 1;

    typedef enum logic [1:0] {RUN, BT_ISSUE, BT_WAIT, CLEAR} state_t;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [LVL_W-1:0] cur_level_reg, cur_level_next;
    logic [LVL_W-1:0] bt_target_reg, bt_target_next;
    logic             bt_done_reg, bt_done_next;
    logic             overflow_reg, overflow_next;
    logic             push_reg;
    logic [VAR_W-1:0] push_var_reg;
    logic             push_value_reg;
    logic [LVL_W-1:0] push_level_reg;
    logic             push_is_dec_reg;

    logic [VAR_W-1:0] prop_var_arr [NUM_PROP];
    logic [CW-1:0]    rr_cand;
    logic [PTR_W-1:0] prop_idx;
    logic             prop_any;
    logic             run, bt_pending, take_clear, take_bt, idle_ok;
    logic             prop_go, dec_elig, dec_go, level_max, bt_finish;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PROP; gi++) begin : g_prop
            assign prop_var_arr[gi] = prop_var[gi*VAR_W +: VAR_W];
            assign prop_ready[gi]   = prop_go && (prop_idx == PTR_W'(gi));
        end
    endgenerate

    // Round-robin search: first valid unit at or after the pointer, wrapping.
    always_comb begin
        prop_any = 1'b0;
        prop_idx = '0;
        rr_cand  = '0;
        for (int k = 0; k < NUM_PROP; k++) begin
            rr_cand = {1'b0, rr_ptr_reg} + CW'(k);
            if (rr_cand >= CW'(NUM_PROP)) rr_cand = rr_cand - CW'(NUM_PROP);
            if (!prop_any && prop_valid[rr_cand[PTR_W-1:0]]) begin
                prop_any = 1'b1;
                prop_idx = rr_cand[PTR_W-1:0];
            end
        end
    end

    // bt_req stays high during its own bt_done cycle, so it is masked there.
    assign run        = (state_reg == RUN) && !reset;
    assign bt_pending = bt_req && !bt_done_reg;
    assign take_clear = run && clear_req;
    assign take_bt    = run && !clear_req && bt_pending;
    assign idle_ok    = run && !clear_req && !bt_pending;
    assign prop_go    = idle_ok && prop_any;
    assign level_max  = (cur_level_reg == '1);
    assign dec_elig   = idle_ok && (prop_valid == '0) && dec_valid;
    assign dec_go     = dec_elig && !level_max;
    assign dec_ready  = dec_go;
    assign bt_finish  = ((state_reg == BT_ISSUE) || (state_reg == BT_WAIT)) && backtrack_done;

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        cur_level_next = cur_level_reg;
        bt_target_next = bt_target_reg;
        bt_done_next   = 1'b0;
        overflow_next  = overflow_reg || (dec_elig && level_max);
        if (prop_go)
            rr_ptr_next = (prop_idx == PTR_W'(NUM_PROP - 1)) ? '0 : prop_idx + PTR_W'(1);
        case (state_reg)
            RUN: begin
                if (take_clear) begin
                    state_next     = CLEAR;
                    cur_level_next = '0;
                end else if (take_bt) begin
                    if (bt_level >= cur_level_reg) begin
                        bt_done_next = 1'b1;
                    end else begin
                        state_next     = BT_ISSUE;
                        bt_target_next = bt_level;
                    end
                end else if (dec_go) begin
                    cur_level_next = cur_level_reg + LVL_W'(1);
                end
            end
            BT_ISSUE: state_next = bt_finish ? RUN : BT_WAIT;
            BT_WAIT:  if (bt_finish) state_next = RUN;
            CLEAR:    state_next = RUN;
            default:  state_next = RUN;
        endcase
        if (bt_finish) begin
            cur_level_next = bt_target_reg;
            bt_done_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= RUN;
            rr_ptr_reg      <= '0;
            cur_level_reg   <= '0;
            bt_target_reg   <= '0;
            bt_done_reg     <= 1'b0;
            overflow_reg    <= 1'b0;
            push_reg        <= 1'b0;
            push_var_reg    <= '0;
            push_value_reg  <= 1'b0;
            push_level_reg  <= '0;
            push_is_dec_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            cur_level_reg <= cur_level_next;
            bt_target_reg <= bt_target_next;
            bt_done_reg   <= bt_done_next;
            overflow_reg  <= overflow_next;
            push_reg      <= prop_go || dec_go;
            if (prop_go) begin
                push_var_reg    <= prop_var_arr[prop_idx];
                push_value_reg  <= prop_value[prop_idx];
                push_level_reg  <= cur_level_reg;
                push_is_dec_reg <= 1'b0;
            end else if (dec_go) begin
                push_var_reg    <= dec_var;
                push_value_reg  <= dec_value;
                push_level_reg  <= cur_level_reg + LVL_W'(1);
                push_is_dec_reg <= 1'b1;
            end else begin
                push_var_reg    <= '0;
                push_value_reg  <= 1'b0;
                push_level_reg  <= '0;
                push_is_dec_reg <= 1'b0;
            end
        end
    end

    assign push               = push_reg;
    assign push_var           = push_var_reg;
    assign push_value         = push_value_reg;
    assign push_level         = push_level_reg;
    assign push_is_decision   = push_is_dec_reg;
    assign backtrack_en       = (state_reg == BT_ISSUE);
    assign backtrack_to_level = backtrack_en ? bt_target_reg : '0;
    assign clear_all          = (state_reg == CLEAR);
    assign bt_done            = bt_done_reg;
    assign cur_level          = cur_level_reg;
    assign level_overflow     = overflow_reg;

endmodule

// File: tb/tb_trail_arbiter.sv
// Scoreboard bench for trail_arbiter: expected pushes are queued at grant time and
// matched against the registered push outputs one cycle later.
module tb_trail_arbiter;
    localparam int NP = 4;
    localparam int VW = 16;
    localparam int LW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     prop_valid;
    logic [NP*VW-1:0]  prop_var;
    logic [NP-1:0]     prop_value;
    logic [NP-1:0]     prop_ready;
    logic              dec_valid;
    logic [VW-1:0]     dec_var;
    logic              dec_value;
    logic              dec_ready;
    logic              bt_req;
    logic [LW-1:0]     bt_level;
    logic              bt_done;
    logic              clear_req;
    logic [LW-1:0]     cur_level;
    logic              level_overflow;
    logic              push;
    logic [VW-1:0]     push_var;
    logic              push_value;
    logic [LW-1:0]     push_level;
    logic              push_is_decision;
    logic              backtrack_en;
    logic [LW-1:0]     backtrack_to_level;
    logic              backtrack_done;
    logic              clear_all;

    trail_arbiter #(.NUM_PROP(NP), .VAR_W(VW), .LVL_W(LW)) dut (
        .clk(clk), .reset(reset),
        .prop_valid(prop_valid), .prop_var(prop_var), .prop_value(prop_value),
        .prop_ready(prop_ready),
        .dec_valid(dec_valid), .dec_var(dec_var), .dec_value(dec_value), .dec_ready(dec_ready),
        .bt_req(bt_req), .bt_level(bt_level), .bt_done(bt_done), .clear_req(clear_req),
        .cur_level(cur_level), .level_overflow(level_overflow),
        .push(push), .push_var(push_var), .push_value(push_value), .push_level(push_level),
        .push_is_decision(push_is_decision),
        .backtrack_en(backtrack_en), .backtrack_to_level(backtrack_to_level),
        .backtrack_done(backtrack_done), .clear_all(clear_all)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] var_idx;
        logic          value;
        logic [LW-1:0] level;
        logic          is_dec;
    } exp_push_t;

    exp_push_t sb[$];
    exp_push_t mon_e;
    int vec_cnt = 0;
    int err_cnt = 0;
    int en_cnt  = 0;
    int clr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic exp_push_t mk(input int v, input int val, input int lvl, input int d);
        exp_push_t e;
        e.var_idx = VW'(v);
        e.value   = val[0];
        e.level   = LW'(lvl);
        e.is_dec  = d[0];
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every observed push must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (backtrack_en) en_cnt++;
            if (clear_all) clr_cnt++;
            if (push) begin
                if (sb.size() == 0) begin
                    check("push_unexpected", 32'(push), 32'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("push_var", 32'(push_var), 32'(mon_e.var_idx));
                    check("push_value", 32'(push_value), 32'(mon_e.value));
                    check("push_level", 32'(push_level), 32'(mon_e.level));
                    check("push_is_dec", 32'(push_is_decision), 32'(mon_e.is_dec));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        prop_valid = '0; prop_var = '0; prop_value = '0;
        dec_valid = 1'b0; dec_var = '0; dec_value = 1'b0;
        bt_req = 1'b0; bt_level = '0; clear_req = 1'b0; backtrack_done = 1'b0;
        for (int i = 0; i < NP; i++) begin
            prop_var[i*VW +: VW] = VW'(10 + i);
            prop_value[i] = 1'(i & 1);
        end
        repeat (3) next_cycle();
        reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_push", 32'(push), 32'(0));
        check("rst_cur_level", 32'(cur_level), 32'(0));
        check("rst_overflow", 32'(level_overflow), 32'(0));
        check("rst_bt_done", 32'(bt_done), 32'(0));
        check("rst_bt_en", 32'(backtrack_en), 32'(0));
        check("rst_clear_all", 32'(clear_all), 32'(0));
        check("rst_prop_ready", 32'(prop_ready), 32'(0));
        check("rst_dec_ready", 32'(dec_ready), 32'(0));

        // round-robin with all units requesting, decision starved
        next_cycle();
        prop_valid = '1;
        dec_valid = 1'b1; dec_var = VW'(77); dec_value = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(prop_ready), 32'(1 << (k % NP)));
            check("rr_dec_ready", 32'(dec_ready), 32'(0));
            if (k > 0) check("rr_push_latency", 32'(push), 32'(1));
            sb.push_back(mk(10 + (k % NP), (k % NP) & 1, 0, 0));
            next_cycle();
        end
        prop_valid = '0;
        dec_valid = 1'b0;
        @(negedge clk);
        check("rr_last_push", 32'(push), 32'(1));

        // level tracking: decision, propagation, decision
        next_cycle();
        dec_valid = 1'b1; dec_var = VW'(1); dec_value = 1'b1;
        @(negedge clk);
        check("lt_dec_ready1", 32'(dec_ready), 32'(1));
        check("lt_prop_ready1", 32'(prop_ready), 32'(0));
        sb.push_back(mk(1, 1, 1, 1));
        next_cycle();
        dec_valid = 1'b0;
        prop_valid = 4'b0001; prop_var[0 +: VW] = VW'(2); prop_value[0] = 1'b0;
        @(negedge clk);
        check("lt_push1", 32'(push), 32'(1));
        check("lt_prop_ready2", 32'(prop_ready), 32'(4'b0001));
        check("lt_level1", 32'(cur_level), 32'(1));
        sb.push_back(mk(2, 0, 1, 0));
        next_cycle();
        prop_valid = '0;
        dec_valid = 1'b1; dec_var = VW'(3); dec_value = 1'b1;
        @(negedge clk);
        check("lt_push2", 32'(push), 32'(1));
        check("lt_dec_ready3", 32'(dec_ready), 32'(1));
        sb.push_back(mk(3, 1, 2, 1));
        next_cycle();
        dec_valid = 1'b0;
        @(negedge clk);
        check("lt_push3", 32'(push), 32'(1));
        check("lt_level2", 32'(cur_level), 32'(2));
        next_cycle();
        @(negedge clk);
        check("lt_idle_push", 32'(push), 32'(0));

        // real backtrack to level 1, trail answers 3 cycles after the pulse
        next_cycle();
        bt_req = 1'b1; bt_level = LW'(1);
        prop_valid = 4'b0100; prop_var[2*VW +: VW] = VW'(20); prop_value[2] = 1'b1;
        dec_valid = 1'b1; dec_var = VW'(99);
        @(negedge clk);
        check("bt_accept_prop_ready", 32'(prop_ready), 32'(0));
        check("bt_accept_dec_ready", 32'(dec_ready), 32'(0));
        next_cycle();
        @(negedge clk);
        check("bt_en", 32'(backtrack_en), 32'(1));
        check("bt_to_level", 32'(backtrack_to_level), 32'(1));
        check("bt_issue_push", 32'(push), 32'(0));
        check("bt_issue_ready", 32'({prop_ready, dec_ready}), 32'(0));
        for (int w = 0; w < 3; w++) begin
            next_cycle();
            if (w == 2) backtrack_done = 1'b1;
            @(negedge clk);
            check("bt_wait_ready", 32'({prop_ready, dec_ready}), 32'(0));
            check("bt_wait_en", 32'(backtrack_en), 32'(0));
            check("bt_wait_done", 32'(bt_done), 32'(0));
        end
        next_cycle();
        backtrack_done = 1'b0;
        @(negedge clk);
        check("bt_done_pulse", 32'(bt_done), 32'(1));
        check("bt_level_after", 32'(cur_level), 32'(1));
        check("bt_post_prop_grant", 32'(prop_ready), 32'(4'b0100));
        check("bt_post_dec_ready", 32'(dec_ready), 32'(0));
        sb.push_back(mk(20, 1, 1, 0));
        next_cycle();
        bt_req = 1'b0; prop_valid = '0; dec_valid = 1'b0;
        @(negedge clk);
        check("bt_done_single", 32'(bt_done), 32'(0));
        check("bt_post_push", 32'(push), 32'(1));
        next_cycle();
        check("bt_en_count", 32'(en_cnt), 32'(1));

        // no-op backtrack: bt_level 3 at level 2
        dec_valid = 1'b1; dec_var = VW'(30); dec_value = 1'b0;
        @(negedge clk);
        check("nop_dec_ready", 32'(dec_ready), 32'(1));
        sb.push_back(mk(30, 0, 2, 1));
        next_cycle();
        dec_valid = 1'b0;
        bt_req = 1'b1; bt_level = LW'(3);
        @(negedge clk);
        check("nop_level2", 32'(cur_level), 32'(2));
        check("nop_done_early", 32'(bt_done), 32'(0));
        next_cycle();
        @(negedge clk);
        check("nop_done", 32'(bt_done), 32'(1));
        check("nop_no_en", 32'(backtrack_en), 32'(0));
        check("nop_level_kept", 32'(cur_level), 32'(2));
        next_cycle();
        bt_req = 1'b0;
        @(negedge clk);
        check("nop_done_single", 32'(bt_done), 32'(0));
        next_cycle();
        check("nop_en_count", 32'(en_cnt), 32'(1));

        // clear with a pending backtrack to level 1
        clear_req = 1'b1; bt_req = 1'b1; bt_level = LW'(1);
        @(negedge clk);
        check("clr_not_yet", 32'(clear_all), 32'(0));
        next_cycle();
        clear_req = 1'b0;
        @(negedge clk);
        check("clr_pulse", 32'(clear_all), 32'(1));
        check("clr_level0", 32'(cur_level), 32'(0));
        check("clr_no_en", 32'(backtrack_en), 32'(0));
        next_cycle();
        @(negedge clk);
        check("clr_single", 32'(clear_all), 32'(0));
        check("clr_bt_pending", 32'(bt_done), 32'(0));
        next_cycle();
        @(negedge clk);
        check("clr_bt_nop_done", 32'(bt_done), 32'(1));
        check("clr_bt_no_en", 32'(backtrack_en), 32'(0));
        check("clr_level_still0", 32'(cur_level), 32'(0));
        next_cycle();
        bt_req = 1'b0;
        check("clr_en_count", 32'(en_cnt), 32'(1));
        check("clr_count", 32'(clr_cnt), 32'(1));

        // overflow: fourth decision refused at level 3 (LVL_W=2)
        dec_valid = 1'b1; dec_value = 1'b1; dec_var = VW'(50);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ovf_level", 32'(cur_level), 32'(k));
            check("ovf_flag_before", 32'(level_overflow), 32'(0));
            if (k < 3) begin
                check("ovf_dec_ready", 32'(dec_ready), 32'(1));
                sb.push_back(mk(50 + k, 1, k + 1, 1));
            end else begin
                check("ovf_dec_refused", 32'(dec_ready), 32'(0));
            end
            next_cycle();
            dec_var = VW'(51 + k);
        end
        @(negedge clk);
        check("ovf_flag", 32'(level_overflow), 32'(1));
        check("ovf_level_max", 32'(cur_level), 32'(3));
        check("ovf_no_push", 32'(push), 32'(0));
        next_cycle();
        dec_valid = 1'b0;
        @(negedge clk);
        check("ovf_sticky", 32'(level_overflow), 32'(1));

        // reset while waiting on the trail
        next_cycle();
        bt_req = 1'b1; bt_level = LW'(0);
        next_cycle();
        @(negedge clk);
        check("rbt_en", 32'(backtrack_en), 32'(1));
        next_cycle();
        @(negedge clk);
        check("rbt_waiting", 32'(backtrack_en), 32'(0));
        next_cycle();
        reset = 1'b1; bt_req = 1'b0;
        #1;
        check("rbt_cur_level", 32'(cur_level), 32'(0));
        check("rbt_overflow", 32'(level_overflow), 32'(0));
        check("rbt_outputs", 32'({push, bt_done, backtrack_en, clear_all, push_is_decision}), 32'(0));
        check("rbt_levels", 32'({push_level, backtrack_to_level}), 32'(0));
        next_cycle();
        reset = 1'b0;
        next_cycle();
        dec_valid = 1'b1; dec_var = VW'(60); dec_value = 1'b0;
        @(negedge clk);
        check("rbt_run_dec", 32'(dec_ready), 32'(1));
        sb.push_back(mk(60, 0, 1, 1));
        next_cycle();
        dec_valid = 1'b0;
        prop_valid = '1; prop_var[0 +: VW] = VW'(10); prop_value[0] = 1'b0;
        @(negedge clk);
        check("rbt_ptr_reset", 32'(prop_ready), 32'(4'b0001));
        sb.push_back(mk(10, 0, 1, 0));
        next_cycle();
        prop_valid = '0;
        @(negedge clk);
        check("rbt_push", 32'(push), 32'(1));
        next_cycle();
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
